// File: rtl/lc3b_types.sv
// Shared LC-3b types: datapath word and the memory arbiter state encoding.
// Pure declarations, no timing.
// No flow control of its own.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } lc3b_arb_state;

endpackage

// File: rtl/register.sv
// Loadable register with asynchronous active-low clear.
// One cycle from load to q.
// No backpressure; load is sampled every clock.
module register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory; MEM_ARBITER_RR_EN selects round-robin ties.
// Grant one cycle after a request in IDLE; resp is same-cycle with pmem_resp.
// Busy owner holds the bus until pmem_resp; other requests wait and an IDLE cycle follows every completion.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_read,
    input  lc3b_word i_address,
    output lc3b_word i_rdata,
    output logic     i_resp,
    input  logic     d_read,
    input  logic     d_write,
    input  lc3b_word d_address,
    input  lc3b_word d_wdata,
    output lc3b_word d_rdata,
    output logic     d_resp,
    output logic     pmem_read,
    output logic     pmem_write,
    output lc3b_word pmem_address,
    output lc3b_word pmem_wdata,
    input  lc3b_word pmem_rdata,
    input  logic     pmem_resp,
    output logic     timeout
);

    localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    lc3b_arb_state state_q, state_d;
    logic          d_req;
    logic          grant_d, grant_i;
    logic          start;
    logic          busy;
    lc3b_word      addr_d, addr_q;
    lc3b_word      wdata_d, wdata_q;
    logic          write_d, write_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_max;
    logic          timeout_q;

    assign d_req = d_read | d_write;

`ifdef MEM_ARBITER_RR_EN
    // last_d_q: 1 when the data port won the most recent grant.
    logic last_d_q;

    always_comb begin
        grant_d = d_req;
        grant_i = i_read & ~d_req;
        if (d_req && i_read) begin
            grant_d = ~last_d_q;
            grant_i = last_d_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if (start) begin
            last_d_q <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
    assign grant_i = i_read & ~d_req;
`endif

    assign start = (state_q == IDLE) && (grant_d || grant_i);
    assign busy  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_BUSY;
                end else if (grant_i) begin
                    state_d = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured once at grant so the bus is immune to requester changes while busy.
    assign addr_d  = grant_d ? d_address : i_address;
    assign wdata_d = grant_d ? d_wdata : '0;
    assign write_d = grant_d & d_write;

    register #(.WIDTH(16)) addr_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .load (start),
        .din  (addr_d),
        .dout (addr_q)
    );

    register #(.WIDTH(16)) wdata_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .load (start),
        .din  (wdata_d),
        .dout (wdata_q)
    );

    register #(.WIDTH(1)) write_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .load (start),
        .din  (write_d),
        .dout (write_q)
    );

    assign pmem_read    = busy & ~write_q;
    assign pmem_write   = busy & write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state_q == I_BUSY) & pmem_resp;
    assign d_resp  = (state_q == D_BUSY) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // cnt_q holds the number of busy cycles so far including the current one, saturating at WAIT_MAX.
    assign at_max = (cnt_q == CW'(WAIT_MAX));

    always_comb begin
        cnt_d = '0;
        if (start) begin
            cnt_d = CW'(1);
        end else if (busy && !pmem_resp) begin
            cnt_d = at_max ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_q | at_max;
        end
    end

    assign timeout = timeout_q | at_max;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level arbitration/watchdog model.
module tb_mem_arbiter;

    localparam int WM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 1'b0;
    logic [15:0] i_address = '0;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_address = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata = '0;
    logic        pmem_resp = 1'b0;
    logic        timeout;

    int n_chk = 0;
    int n_fail = 0;
    bit last_d_m = 1'b0;
    bit tout_m = 1'b0;

    mem_arbiter #(.WAIT_MAX(WM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arbitration rule: data has priority unless round-robin alternates ties.
    function automatic bit pick_d(input bit ir, input bit dq);
`ifdef MEM_ARBITER_RR_EN
        if (ir && dq) return !last_d_m;
`endif
        return dq;
    endfunction

    task automatic set_req(input bit ir, input bit dr, input bit dw,
                           input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd);
        i_read    = ir;
        d_read    = dr;
        d_write   = dw;
        i_address = ia;
        d_address = da;
        d_wdata   = wd;
    endtask

    // One cycle in IDLE: the bus must stay quiet whatever pmem_resp does.
    task automatic idle_cycle(input bit spur);
        pmem_resp  = spur;
        pmem_rdata = 16'($urandom);
        #1;
        check("idle_pmem_read", 32'(pmem_read), 32'(0));
        check("idle_pmem_write", 32'(pmem_write), 32'(0));
        check("idle_i_resp", 32'(i_resp), 32'(0));
        check("idle_d_resp", 32'(d_resp), 32'(0));
        check("idle_timeout", 32'(timeout), 32'(tout_m));
        @(posedge clk);
        @(negedge clk);
    endtask

    // One granted access of lat busy cycles; mode 1 scrambles requester inputs, mode 2 moves d_address.
    task automatic serve(input bit exp_d, input bit exp_w, input logic [15:0] exp_a,
                         input logic [15:0] exp_wd, input int lat, input int mode, input int rdv);
        logic [15:0] rd;
        for (int k = 1; k <= lat; k++) begin
            if (mode == 1) begin
                i_read    = 1'($urandom);
                d_read    = 1'($urandom);
                d_write   = 1'($urandom);
                i_address = 16'($urandom);
                d_address = 16'($urandom);
                d_wdata   = 16'($urandom);
            end else if (mode == 2 && k >= 2) begin
                d_address = 16'h0200;
            end
            rd         = (rdv < 0) ? 16'($urandom) : 16'(rdv);
            pmem_rdata = rd;
            pmem_resp  = (k == lat);
            #1;
            check("pmem_read", 32'(pmem_read), 32'(!exp_w));
            check("pmem_write", 32'(pmem_write), 32'(exp_w));
            check("pmem_address", 32'(pmem_address), 32'(exp_a));
            if (exp_w) check("pmem_wdata", 32'(pmem_wdata), 32'(exp_wd));
            check("i_resp", 32'(i_resp), 32'((k == lat) && !exp_d));
            check("d_resp", 32'(d_resp), 32'((k == lat) && exp_d));
            if (k == lat && exp_d) check("d_rdata", 32'(d_rdata), 32'(rd));
            if (k == lat && !exp_d) check("i_rdata", 32'(i_rdata), 32'(rd));
            check("busy_timeout", 32'(timeout), 32'(tout_m || (k >= WM)));
            @(posedge clk);
            @(negedge clk);
        end
        if (lat >= WM) tout_m = 1'b1;
        last_d_m = exp_d;
    endtask

    // Reset with every requester and pmem_resp active; outputs must still be zero.
    task automatic do_reset();
        rst_n = 1'b0;
        set_req(1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        pmem_resp  = 1'b1;
        pmem_rdata = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_pmem_read", 32'(pmem_read), 32'(0));
        check("rst_pmem_write", 32'(pmem_write), 32'(0));
        check("rst_i_resp", 32'(i_resp), 32'(0));
        check("rst_d_resp", 32'(d_resp), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));
        check("rst_pmem_address", 32'(pmem_address), 32'(0));
        check("rst_pmem_wdata", 32'(pmem_wdata), 32'(0));
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        pmem_resp = 1'b0;
        rst_n     = 1'b1;
        last_d_m  = 1'b0;
        tout_m    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit ord[4];
        bit ir, dr, dw, spur, ed, ew;
        logic [15:0] ia, da, wd;
        int lat;

`ifdef MEM_ARBITER_RR_EN
        ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif

        @(negedge clk);
        do_reset();

        // Lone fetch, memory answers on the third busy cycle.
        set_req(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000);
        idle_cycle(1'b0);
        serve(1'b0, 1'b0, 16'h0040, 16'h0000, 3, 0, 32'h1234);

        // Fetch and write together: data first, one IDLE cycle, then fetch.
        set_req(1'b1, 1'b0, 1'b1, 16'h3000, 16'h0100, 16'hBEEF);
        idle_cycle(1'b0);
        serve(1'b1, 1'b1, 16'h0100, 16'hBEEF, 2, 0, -1);
        set_req(1'b1, 1'b0, 1'b0, 16'h3000, 16'h0100, 16'hBEEF);
        idle_cycle(1'b0);
        serve(1'b0, 1'b0, 16'h3000, 16'h0000, 2, 0, -1);

        // Data address moves mid-transaction.
        set_req(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0000);
        idle_cycle(1'b0);
        serve(1'b1, 1'b0, 16'h0100, 16'h0000, 4, 2, -1);

        // Both ports requesting continuously from reset.
        do_reset();
        set_req(1'b1, 1'b0, 1'b1, 16'h3000, 16'h0100, 16'hBEEF);
        for (int n = 0; n < 4; n++) begin
            idle_cycle(1'b0);
            serve(ord[n], ord[n], ord[n] ? 16'h0100 : 16'h3000, 16'hBEEF, 2, 0, -1);
        end

        // Random traffic against the arbitration model.
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle_cycle(1'b0);
        for (int t = 0; t < 60; t++) begin
            ir   = 1'($urandom);
            dr   = 1'($urandom);
            dw   = 1'($urandom);
            spur = 1'($urandom);
            ia   = 16'($urandom);
            da   = 16'($urandom);
            wd   = 16'($urandom);
            lat  = int'($urandom_range(1, 5));
            set_req(ir, dr, dw, ia, da, wd);
            idle_cycle(spur);
            if (ir || dr || dw) begin
                ed = pick_d(ir, dr | dw);
                ew = ed & dw;
                serve(ed, ew, ed ? da : ia, wd, lat, 1, -1);
            end
        end

        // Reset while D_BUSY with pmem_resp in the same cycle.
        set_req(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0100, 16'hBEEF);
        idle_cycle(1'b0);
        serve(1'b1, 1'b1, 16'h0100, 16'hBEEF, 0, 0, -1);
        pmem_resp = 1'b0;
        #1;
        check("pre_rst_pmem_write", 32'(pmem_write), 32'(1));
        @(posedge clk);
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = 16'h0000;
        rst_n      = 1'b0;
        #1;
        check("midrst_d_resp", 32'(d_resp), 32'(0));
        check("midrst_i_resp", 32'(i_resp), 32'(0));
        check("midrst_pmem_write", 32'(pmem_write), 32'(0));
        check("midrst_pmem_read", 32'(pmem_read), 32'(0));
        check("midrst_pmem_address", 32'(pmem_address), 32'(0));
        check("midrst_pmem_wdata", 32'(pmem_wdata), 32'(0));
        check("midrst_timeout", 32'(timeout), 32'(0));
        check("midrst_d_rdata", 32'(d_rdata), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        last_d_m = 1'b0;
        tout_m   = 1'b0;
        idle_cycle(1'b0);

        // Watchdog: response withheld for 12 cycles, arriving on the 13th.
        set_req(1'b1, 1'b0, 1'b0, 16'h1111, 16'h0000, 16'h0000);
        idle_cycle(1'b0);
        serve(1'b0, 1'b0, 16'h1111, 16'h0000, 13, 0, -1);
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle_cycle(1'b0);
        set_req(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0ABC, 16'h0000);
        idle_cycle(1'b0);
        serve(1'b1, 1'b0, 16'h0ABC, 16'h0000, 2, 0, -1);
        set_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        idle_cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
